// File: rtl/rom_loader.sv
// rom_loader: byte-stream writer that fills a RAM image from a host download
// channel. Bytes are written at sequential addresses from 0. The loader
// reports completion, byte count, overflow and a modulo-256 checksum.
//
// Build option: define ROM_LOADER_CHECKSUM_EN to build the checksum
// accumulator. Without it, the checksum port is tied to zero.
module rom_loader #(
  parameter int addrbits = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                we,
  output logic [addrbits-1:0] a,
  output logic [7:0]          d,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [addrbits:0]   count,
  output logic [7:0]          checksum
);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_load  = 2'd1,
    st_drain = 2'd2,
    st_done  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                in_ready_s;
  logic                accept_s;
  logic                at_top_s;
  logic                we_r;
  logic [addrbits-1:0] a_r;
  logic [7:0]          d_r;
  logic                busy_r;
  logic                done_r;
  logic                overflow_r;
  logic [addrbits:0]   count_r;

  // Handshake, accept qualification and next-state selection.
  always_comb begin
    state_s    = state_r;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    at_top_s   = 1'b0;
    // A start pulse blocks acceptance for its own cycle.
    if (((state_r == st_load) || (state_r == st_drain)) && !start) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    accept_s = in_valid && in_ready_s;
    // While loading, count is below capacity, so all-ones low bits mark the
    // final RAM address.
    at_top_s = &count_r[addrbits-1:0];
    if (start) begin
      state_s = st_load;
    end else begin
      case (state_r)
        st_idle: begin
          state_s = st_idle;
        end
        st_load: begin
          if (accept_s) begin
            if (in_last) begin
              state_s = st_done;
            end else if (at_top_s) begin
              state_s = st_drain;
            end else begin
              state_s = st_load;
            end
          end else begin
            state_s = st_load;
          end
        end
        st_drain: begin
          if (accept_s && in_last) begin
            state_s = st_done;
          end else begin
            state_s = st_drain;
          end
        end
        st_done: begin
          state_s = st_done;
        end
        default: begin
          state_s = st_idle;
        end
      endcase
    end
  end

  // State register, status flags, write port and byte counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= st_idle;
      we_r       <= 1'b0;
      a_r        <= '0;
      d_r        <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      count_r    <= '0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == st_load) || (state_s == st_drain);
      done_r  <= (state_s == st_done);
      if (start) begin
        we_r       <= 1'b0;
        overflow_r <= 1'b0;
        count_r    <= '0;
      end else if (accept_s && (state_r == st_load)) begin
        we_r    <= 1'b1;
        a_r     <= count_r[addrbits-1:0];
        d_r     <= in_data;
        count_r <= count_r + (addrbits+1)'(1);
      end else if (accept_s && (state_r == st_drain)) begin
        // Bytes past capacity are consumed but never written.
        we_r       <= 1'b0;
        overflow_r <= 1'b1;
      end else begin
        we_r <= 1'b0;
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_r;

  // Modulo-256 sum of bytes actually written to RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum_r <= 8'd0;
    end else if (start) begin
      checksum_r <= 8'd0;
    end else if (accept_s && (state_r == st_load)) begin
      checksum_r <= checksum_r + in_data;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = 8'd0;
`endif

  assign in_ready = in_ready_s;
  assign we       = we_r;
  assign a        = a_r;
  assign d        = d_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = overflow_r;
  assign count    = count_r;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader (addrbits=4). The reference model tracks the load as
// "active / written-so-far / running sum", with no notion of RTL states.
module tb_rom_loader;

  localparam int AB  = 4;
  localparam int CAP = 1 << AB;

  logic          clock;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          we;
  logic [AB-1:0] a;
  logic [7:0]    d;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AB:0]   count;
  logic [7:0]    checksum;

  int compared;
  int mismatched;

  // reference model
  bit m_active;
  bit m_done;
  bit m_ovf;
  bit m_we;
  int m_cnt;
  int m_sum;
  int m_a;
  int m_d;

  rom_loader #(.addrbits(AB)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .we       (we),
    .a        (a),
    .d        (d),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .count    (count),
    .checksum (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input logic [7:0] dat, input bit l);
    if (r) begin
      m_active = 0; m_done = 0; m_ovf = 0; m_we = 0;
      m_cnt = 0; m_sum = 0; m_a = 0; m_d = 0;
    end else if (s) begin
      m_active = 1; m_done = 0; m_ovf = 0; m_we = 0;
      m_cnt = 0; m_sum = 0;
    end else begin
      m_we = 0;
      if (m_active && v) begin
        if (m_cnt < CAP) begin
          m_we = 1; m_a = m_cnt; m_d = int'(dat);
          m_cnt = m_cnt + 1;
          m_sum = (m_sum + int'(dat)) % 256;
        end else begin
          m_ovf = 1;
        end
        if (l) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("we", 32'(we), 32'(m_we));
    chk("a", 32'(a), 32'(m_a));
    chk("d", 32'(d), 32'(m_d));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("count", 32'(count), 32'(m_cnt));
`ifdef ROM_LOADER_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(m_sum));
`else
    chk("checksum", 32'(checksum), 32'd0);
`endif
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic cyc(input bit s, input bit v, input logic [7:0] dat, input bit l, input bit r);
    @(negedge clock);
    start = s; in_valid = v; in_data = dat; in_last = l; reset = r;
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_active && !s));
    @(posedge clock);
    model_step(r, s, v, dat, l);
    #1;
    check_outputs();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic load_n(input int n, input bit alternate);
    for (int i = 0; i < n; i++) begin
      if (alternate) idle_cyc();
      cyc(1'b0, 1'b1, 8'($urandom), (i == n - 1), 1'b0);
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    m_active = 0; m_done = 0; m_ovf = 0; m_we = 0;
    m_cnt = 0; m_sum = 0; m_a = 0; m_d = 0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (2) @(posedge clock);
    // reset state, including in_ready low while idle
    cyc(1'b0, 1'b1, 8'h5a, 1'b0, 1'b1);
    idle_cyc();
    cyc(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);

    // 4 bytes back-to-back, checksum 0xAA
    cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h44, 1'b1, 1'b0);
    chk("plan1_count", 32'(count), 32'd4);
    chk("plan1_done", 32'(done), 32'd1);
    idle_cyc();
    cyc(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);

    // exactly at capacity: no overflow
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= CAP; i++) cyc(1'b0, 1'b1, 8'(i), (i == CAP), 1'b0);
    chk("cap_overflow", 32'(overflow), 32'd0);
    chk("cap_count", 32'(count), 32'(CAP));
    idle_cyc();

    // 18 bytes: two past capacity
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    load_n(CAP + 2, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    idle_cyc();

    // valid toggling every other cycle
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    load_n(6, 1'b1);
    idle_cyc();

    // restart after 5 bytes mid-load
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hee, 1'b0, 1'b0);
    load_n(3, 1'b0);
    idle_cyc();

    // reset one cycle after an accept, then reset coinciding with an accept
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h3c, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h4d, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h5e, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h6f, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h70, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
